uart_rx: RTL and testbench

//  Asynchronous serial receiver, 8N1, for the icestick FTDI RX pin at 12 MHz clk.

---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/uart_rx_if.sv | 11 +
 rtl/uart_baud_cnt.sv | 29 ++
 rtl/uart_rx.sv | 171 +++++++++++++++++
 tb/tb_uart_rx.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the serial link: receiver state encodings and
// default clock/baud values, kept here so the future transmitter can reuse them.
package uart_rx_pkg;

    localparam int DEF_CLK_HZ = 12_000_000;
    localparam int DEF_BAUD   = 115_200;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // Clocks per bit for a given system clock and line rate.
    function automatic int div_of(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, byte and status strobes out.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (output rx, input data, input valid, input frame_err, input busy);
    modport slave  (input rx, output data, output valid, output frame_err, output busy);
endinterface

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter timing the bit slots; tick is high while the count sits at zero.
module uart_baud_cnt #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tick
);

    logic [W-1:0] cnt_r;

    // Count down to zero and hold there until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises rx, samples each bit at mid-bit and
// strobes valid for a good frame or frame_err when the stop bit is low.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ,
    parameter int BAUD   = DEF_BAUD
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

    localparam int DIV   = div_of(CLK_HZ, BAUD);
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LOAD_FULL = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] LOAD_HALF = CNT_W'(HALF - 1);

    logic [1:0]       sync_r;
    logic             rx_s;
    rx_state_t        state_r, state_nxt;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shreg_r;
    logic [7:0]       data_r;
    logic             valid_r;
    logic             frame_err_r;
    logic             busy_r;
    logic             tick;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             shift_en;
    logic             capture;
    logic             ferr_set;

    assign rx_s = sync_r[1];

    uart_baud_cnt #(.W(CNT_W)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tick     (tick)
    );

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], bus.rx};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic and per-cycle control decisions.
    always_comb begin
        state_nxt = state_r;
        cnt_load  = 1'b0;
        cnt_val   = LOAD_FULL;
        shift_en  = 1'b0;
        capture   = 1'b0;
        ferr_set  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nxt = ST_START;
                    cnt_load  = 1'b1;
                    cnt_val   = LOAD_HALF;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_nxt = ST_DATA;
                        cnt_load  = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    cnt_load = 1'b1;
                    if (bit_idx_r == 3'd7) begin
                        state_nxt = ST_STOP;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end else begin
                    state_nxt = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        capture   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = ST_BREAK;
                    end
                end else begin
                    state_nxt = ST_STOP;
                end
            end
            // A held-low line stays here so it reports only one frame error.
            ST_BREAK: begin
                if (rx_s) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_BREAK;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bit index and LSB-first shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx_r <= 3'd0;
            shreg_r   <= 8'h00;
        end else if (state_r != ST_DATA) begin
            bit_idx_r <= 3'd0;
            shreg_r   <= shreg_r;
        end else if (shift_en) begin
            bit_idx_r <= (bit_idx_r == 3'd7) ? bit_idx_r : bit_idx_r + 3'd1;
            shreg_r   <= {rx_s, shreg_r[7:1]};
        end else begin
            bit_idx_r <= bit_idx_r;
            shreg_r   <= shreg_r;
        end
    end

    // Registered outputs; strobes last exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r      <= 8'h00;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            data_r      <= capture ? shreg_r : data_r;
            valid_r     <= capture;
            frame_err_r <= ferr_set;
            busy_r      <= (state_nxt != ST_IDLE);
        end
    end

    assign bus.data      = data_r;
    assign bus.valid     = valid_r;
    assign bus.frame_err = frame_err_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// sequences for idle, back-to-back, glitch, break and mid-frame reset.
module tb_uart_rx;

    logic clk;
    logic rst;

    uart_rx_if bus ();

    uart_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Strobe monitor, sampled on the falling edge.
    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         rule_viol = 0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] prev_data = 8'h00;
    logic       prev_v    = 1'b0;
    logic       prev_f    = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid) begin
                valid_cnt <= valid_cnt + 1;
                prev_data <= last_data;
                last_data <= bus.data;
            end
            if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
            if ((bus.valid && bus.frame_err) || (bus.valid && prev_v) || (bus.frame_err && prev_f))
                rule_viol <= rule_viol + 1;
        end
        prev_v <= bus.valid;
        prev_f <= bus.frame_err;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_clks(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int per, input logic stop_bit);
        bus.rx = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (per) @(negedge clk);
        end
        bus.rx = stop_bit;
        repeat (per) @(negedge clk);
        bus.rx = 1'b1;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (bus.busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(nm, {31'd0, bus.busy}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] value;
        int         per;
        logic [7:0] exp;
    } vec_t;

    vec_t vt [6];
    int   bv, bf;

    initial begin
        vt[0] = '{value: 8'hA5, per: 104, exp: 8'hA5};
        vt[1] = '{value: 8'hA5, per: 100, exp: 8'hA5};
        vt[2] = '{value: 8'hA5, per: 108, exp: 8'hA5};
        vt[3] = '{value: 8'h01, per: 104, exp: 8'h01};
        vt[4] = '{value: 8'h80, per: 104, exp: 8'h80};
        vt[5] = '{value: 8'h3C, per: 104, exp: 8'h3C};

        bus.rx = 1'b1;
        rst    = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;

        // Idle line after reset.
        idle_clks(2000);
        check("idle_valid", valid_cnt, 32'd0);
        check("idle_ferr", ferr_cnt, 32'd0);
        check("idle_busy", {31'd0, bus.busy}, 32'd0);
        check("idle_data", {24'd0, bus.data}, 32'd0);

        // Single frames, including off-nominal bit periods.
        for (int i = 0; i < 6; i++) begin
            bv = valid_cnt;
            bf = ferr_cnt;
            send_frame(vt[i].value, vt[i].per, 1'b1);
            wait_idle($sformatf("row%0d_busy", i));
            idle_clks(208);
            check($sformatf("row%0d_nvalid", i), valid_cnt - bv, 32'd1);
            check($sformatf("row%0d_nferr", i), ferr_cnt - bf, 32'd0);
            check($sformatf("row%0d_data", i), {24'd0, bus.data}, {24'd0, vt[i].exp});
        end

        // Back-to-back frames with no idle gap.
        bv = valid_cnt;
        send_frame(8'h00, 104, 1'b1);
        send_frame(8'hFF, 104, 1'b1);
        wait_idle("b2b_busy");
        idle_clks(208);
        check("b2b_nvalid", valid_cnt - bv, 32'd2);
        check("b2b_first", {24'd0, prev_data}, 32'h00);
        check("b2b_second", {24'd0, bus.data}, 32'hFF);

        // Short low glitch must be rejected at the start-bit mid-sample.
        bv = valid_cnt;
        bf = ferr_cnt;
        bus.rx = 1'b0;
        repeat (30) @(negedge clk);
        idle_clks(300);
        check("glitch_busy", {31'd0, bus.busy}, 32'd0);
        check("glitch_nvalid", valid_cnt - bv, 32'd0);
        check("glitch_nferr", ferr_cnt - bf, 32'd0);

        // Bad stop bit followed by a held-low line, then a good frame.
        bv = valid_cnt;
        bf = ferr_cnt;
        send_frame(8'h3C, 104, 1'b0);
        bus.rx = 1'b0;
        repeat (3 * 104) @(negedge clk);
        check("brk_busy_held", {31'd0, bus.busy}, 32'd1);
        idle_clks(208);
        check("brk_busy_rel", {31'd0, bus.busy}, 32'd0);
        check("brk_nferr", ferr_cnt - bf, 32'd1);
        check("brk_nvalid", valid_cnt - bv, 32'd0);
        check("brk_data_kept", {24'd0, bus.data}, 32'hFF);
        send_frame(8'h5A, 104, 1'b1);
        wait_idle("brk_after_busy");
        idle_clks(104);
        check("brk_after_nvalid", valid_cnt - bv, 32'd1);
        check("brk_after_data", {24'd0, bus.data}, 32'h5A);

        // Reset during bit 4 of 8'hC3 discards the frame.
        bv = valid_cnt;
        bf = ferr_cnt;
        bus.rx = 1'b0;
        repeat (104) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx = ((8'hC3 >> i) & 8'h01) != 8'h00;
            repeat (104) @(negedge clk);
        end
        bus.rx = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        bus.rx = 1'b1;
        rst = 1'b0;
        check("rst_data", {24'd0, bus.data}, 32'h00);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        idle_clks(600);
        check("rst_nvalid", valid_cnt - bv, 32'd0);
        check("rst_nferr", ferr_cnt - bf, 32'd0);
        send_frame(8'h81, 104, 1'b1);
        wait_idle("rst_after_busy");
        idle_clks(104);
        check("rst_after_nvalid", valid_cnt - bv, 32'd1);
        check("rst_after_data", {24'd0, bus.data}, 32'h81);

        check("strobe_rules", rule_viol, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
